rx_bus_cdc_synch: RTL and testbench
===================================

# rx_bus_cdc_synch

Parametrised multi-channel bus synchroniser that carries CH independent WIDTH-bit values, such as committed read addresses and producer/consumer pointers, from the clk_in domain to the clk_out domain. Each channel uses a 2-phase toggle req/ack handshake, so transfer timing follows the actual clock ratio instead of a fixed source-side delay. It adds per-channel busy, per-channel forced resend, and a destination-side update strobe. It sits between the rx DMA engine (clk_in) and the host-interface logic (clk_out).

## Interface
Parameters:
- CH, default 2: number of independent channels (≥1).
- WIDTH, default 16: bits per channel (≥1).
- SYNC_STAGES, default 2: flip-flops per synchroniser chain, each direction (≥2).

Ports:
- clk_in  input  1  source-domain clock.
- reset_n_clk_in  input  1  reset reset_n_clk_in, asynchronous, active-low; clock clk_in.
- clk_out  input  1  destination-domain clock.
- reset_n_clk_out  input  1  destination reset, asynchronous, active-low; clock clk_out.
- bus_in  input  CH*WIDTH  source values; channel i at [i*WIDTH +: WIDTH]; clk_in domain.
- force_in  input  CH  clk_in pulse: resend channel i's current value even if unchanged.
- busy  output  CH  clk_in domain; 1 while channel i has a transfer in flight.
- bus_out  output  CH*WIDTH  synchronised values; clk_out domain, registered.
- update_out  output  CH  clk_out one-cycle pulse when bus_out channel i is loaded.

## Operation
Per channel i, source side (clk_in):
- Registers: last[i], hold[i], req[i], pend[i], ack_sync[i][SYNC_STAGES-1:0].
- busy[i] = req[i] XOR ack_sync[i][SYNC_STAGES-1]. It is decoded from registers with no added latency.
- A force_in[i] pulse sets pend[i].
- Launch condition: !busy[i] AND (bus_in[i] != last[i] OR pend[i]).
- On launch: hold[i] <= bus_in[i], last[i] <= bus_in[i], req[i] toggles, pend[i] clears.
- hold[i] is stable whenever busy[i]=1. Destination captures only hold, never bus_in.
- A force_in[i] arriving while busy is kept in pend[i] and launched once idle. Multiple forces merge into one resend.
- If bus_in changes several times while busy, only the value present at the next idle cycle is sent. Intermediate values are dropped by design.

Per channel i, destination side (clk_out):
- Registers: req_sync[i][SYNC_STAGES-1:0], req_seen[i].
- When req_sync[i][SYNC_STAGES-1] != req_seen[i]: bus_out[i] <= hold[i], req_seen[i] toggles, update_out[i] <= 1.
- Otherwise update_out[i] <= 0.
- ack[i] = req_seen[i], fed to the source ack_sync chain.

General:
- Channels are fully independent. Simultaneous launches on all channels are allowed.
- Only 1-bit toggles cross the domains. The WIDTH-bit hold bus is quasi-static and carries no synchroniser.

## Timing
- Reset, source domain: last, hold, req, pend, ack_sync = 0. busy = 0.
- Reset, destination domain: req_sync, req_seen, bus_out, update_out = 0.
- Source latency: bus_in change sampled at edge n → req toggles at edge n.
- Destination latency: req toggle visible at req_sync[SYNC_STAGES-1] after SYNC_STAGES clk_out edges. bus_out and update_out follow on the next edge, i.e. SYNC_STAGES+1 clk_out edges after the req toggle (plus up to 1 cycle of phase uncertainty).
- busy clears SYNC_STAGES clk_in edges after ack toggles. A new launch is allowed in that same cycle.
- Minimum round trip ≈ (SYNC_STAGES+1)·Tout + SYNC_STAGES·Tin.
- No value change is sent with bus_in == last and pend=0: an unchanged value never generates update_out.
- Destination reset mid-transfer: req_seen=0 on exit. If req[i]=1, the destination sees a toggle, loads the stable hold, pulses update_out, and ack re-converges. No deadlock.
- Source reset mid-transfer: req=0, last=0, hold=0. The stale ack_sync may make busy=1 transiently. The destination may see one toggle and load 0, and the handshake re-converges. The final bus_out equals the source value sent after reset.
- Equality on release: busy deasserts only when ack equals req, so no overlap of two in-flight transfers per channel.

## Test plan
- Reset both domains, then hold bus_in=0 → bus_out=0, update_out never pulses, busy stays 0.
- CH=2, WIDTH=16, SYNC_STAGES=2, clk_in 250 MHz, clk_out 125 MHz. Set ch0 0x1234 → bus_out ch0=0x1234 in 3–4 clk_out edges, one update_out[0] pulse, ch1 untouched.
- Ch0 steps 0x0001→0x0002→0x0003 on consecutive clk_in cycles while busy → bus_out shows 0x0001 then 0x0003 only, 2 update_out pulses, final value matches.
- force_in[1] with ch1 steady at 0xBEEF → exactly one extra update_out[1] with 0xBEEF. Three forces while busy → exactly one resend.
- Assert reset_n_clk_out mid-transfer of 0x00AA → after release, bus_out=0x00AA, busy clears, no hang.
- Assert reset_n_clk_in mid-transfer → busy settles to 0 within 2·SYNC_STAGES+2 cycles; a subsequent 0x5555 reaches bus_out correctly. Also repeat every scenario with clk_out faster than clk_in.

Source files
------------

// File: rtl/rx_bus_cdc_synch.sv
// Multi-channel bus synchroniser clk_in -> clk_out using a 2-phase toggle req/ack per channel.
// Latency SYNC_STAGES+1 clk_out edges to bus_out; busy holds off new launches until ack returns.
module rx_bus_cdc_synch #(
    parameter int CH          = 2,
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  reset_n_clk_in,
    input  logic                  clk_out,
    input  logic                  reset_n_clk_out,
    input  logic [CH*WIDTH-1:0]   bus_in,
    input  logic [CH-1:0]         force_in,
    output logic [CH-1:0]         busy,
    output logic [CH*WIDTH-1:0]   bus_out,
    output logic [CH-1:0]         update_out
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [WIDTH-1:0]       w_val;
        logic                   w_busy;
        logic                   w_launch;
        logic [WIDTH-1:0]       r_last;
        logic [WIDTH-1:0]       r_hold;
        logic                   r_req;
        logic                   r_pend;
        logic [SYNC_STAGES-1:0] r_ack_sync;
        logic [SYNC_STAGES-1:0] r_req_sync;
        logic                   r_req_seen;
        logic [WIDTH-1:0]       r_bus_out;
        logic                   r_update;

        assign w_val    = bus_in[g*WIDTH +: WIDTH];
        assign w_busy   = r_req ^ r_ack_sync[SYNC_STAGES-1];
        assign w_launch = !w_busy && ((w_val != r_last) || r_pend);

        // Source side: hold is only rewritten while idle, so it is quasi-static
        // for the whole time the destination may sample it.
        always_ff @(posedge clk_in or negedge reset_n_clk_in) begin
            if (!reset_n_clk_in) begin
                r_last     <= '0;
                r_hold     <= '0;
                r_req      <= 1'b0;
                r_pend     <= 1'b0;
                r_ack_sync <= '0;
            end else begin
                r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_req_seen};
                if (w_launch) begin
                    r_hold <= w_val;
                    r_last <= w_val;
                    r_req  <= ~r_req;
                    r_pend <= 1'b0;
                end else if (force_in[g]) begin
                    r_pend <= 1'b1;
                end
            end
        end

        always_ff @(posedge clk_out or negedge reset_n_clk_out) begin
            if (!reset_n_clk_out) begin
                r_req_sync <= '0;
                r_req_seen <= 1'b0;
                r_bus_out  <= '0;
                r_update   <= 1'b0;
            end else begin
                r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req};
                if (r_req_sync[SYNC_STAGES-1] != r_req_seen) begin
                    r_bus_out  <= r_hold;
                    r_req_seen <= ~r_req_seen;
                    r_update   <= 1'b1;
                end else begin
                    r_update   <= 1'b0;
                end
            end
        end

        assign busy[g]                    = w_busy;
        assign bus_out[g*WIDTH +: WIDTH]  = r_bus_out;
        assign update_out[g]              = r_update;
    end

endmodule

// File: tb/tb_rx_bus_cdc_synch.sv
// Bench for rx_bus_cdc_synch: per-channel expected-value queues checked on every update_out pulse.
`timescale 1ns/1ps
module tb_rx_bus_cdc_synch;
    localparam int CH = 2;
    localparam int W  = 16;
    localparam int SS = 2;

    logic              clk_in = 1'b0;
    logic              clk_out = 1'b0;
    logic              reset_n_clk_in;
    logic              reset_n_clk_out;
    logic [CH*W-1:0]   bus_in;
    logic [CH-1:0]     force_in;
    logic [CH-1:0]     busy;
    logic [CH*W-1:0]   bus_out;
    logic [CH-1:0]     update_out;

    int half_in  = 2;
    int half_out = 4;
    int errors   = 0;
    int checks   = 0;
    logic [W-1:0] exp_q [CH][$];
    int  upd_cnt [CH];
    int  tog [CH];
    bit  sb_en = 1'b0;

    rx_bus_cdc_synch #(.CH(CH), .WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk_in          (clk_in),
        .reset_n_clk_in  (reset_n_clk_in),
        .clk_out         (clk_out),
        .reset_n_clk_out (reset_n_clk_out),
        .bus_in          (bus_in),
        .force_in        (force_in),
        .busy            (busy),
        .bus_out         (bus_out),
        .update_out      (update_out)
    );

    initial forever #(half_in)  clk_in  = ~clk_in;
    initial forever #(half_out) clk_out = ~clk_out;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Scoreboard: every update pulse must match the oldest expected value of its channel.
    always @(negedge clk_out) begin
        logic [W-1:0] e;
        if (reset_n_clk_out) begin
            for (int c = 0; c < CH; c++) begin
                if (update_out[c]) begin
                    upd_cnt[c] = upd_cnt[c] + 1;
                    if (sb_en) begin
                        checks++;
                        if (exp_q[c].size() == 0) begin
                            errors++;
                            $display("FAIL sb_unexpected ch%0d: update with 0x%h, none expected", c, bus_out[c*W +: W]);
                        end else begin
                            e = exp_q[c].pop_front();
                            if (bus_out[c*W +: W] !== e) begin
                                errors++;
                                $display("FAIL sb_value ch%0d: got 0x%h, expected 0x%h", c, bus_out[c*W +: W], e);
                            end
                        end
                    end
                end
            end
        end
    end

    function automatic logic [W-1:0] out_ch(int c);
        return bus_out[c*W +: W];
    endfunction

    task automatic set_ch(int c, logic [W-1:0] v);
        bus_in[c*W +: W] = v;
    endtask

    task automatic expect_launch(int c, logic [W-1:0] v);
        exp_q[c].push_back(v);
        tog[c]++;
    endtask

    task automatic drain(string name);
        int quiet = 0;
        bit done  = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(posedge clk_in); #1;
            if (busy == '0 && exp_q[0].size() == 0 && exp_q[1].size() == 0) quiet++;
            else quiet = 0;
            if (quiet >= 16) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_%s: busy=%b pending=%0d/%0d, expected idle and empty", name, busy, exp_q[0].size(), exp_q[1].size());
        end
    endtask

    task automatic test_reset(int hi, int ho);
        reset_n_clk_in  = 1'b0;
        reset_n_clk_out = 1'b0;
        bus_in   = '0;
        force_in = '0;
        sb_en    = 1'b0;
        for (int c = 0; c < CH; c++) begin
            exp_q[c].delete();
            tog[c] = 0;
        end
        half_in  = hi;
        half_out = ho;
        #40;
        checks++;
        if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++;
        if (bus_out !== '0) begin errors++; $display("FAIL reset_bus_out: got 0x%h, expected 0", bus_out); end
        checks++;
        if (update_out !== '0) begin errors++; $display("FAIL reset_update: got %b, expected 0", update_out); end
        @(posedge clk_in);  #1 reset_n_clk_in  = 1'b1;
        @(posedge clk_out); #1 reset_n_clk_out = 1'b1;
        sb_en = 1'b1;
        for (int c = 0; c < CH; c++) upd_cnt[c] = 0;
        repeat (30) @(posedge clk_out);
        #1;
        checks++;
        if (upd_cnt[0] + upd_cnt[1] != 0) begin errors++; $display("FAIL idle_updates: got %0d pulses, expected 0", upd_cnt[0] + upd_cnt[1]); end
        checks++;
        if (busy !== '0) begin errors++; $display("FAIL idle_busy: got %b, expected 0", busy); end
        checks++;
        if (bus_out !== '0) begin errors++; $display("FAIL idle_bus_out: got 0x%h, expected 0", bus_out); end
    endtask

    task automatic test_single();
        int lat = 0;
        bit got = 1'b0;
        @(posedge clk_in); #1 set_ch(0, 16'h1234);
        @(posedge clk_in);
        expect_launch(0, 16'h1234);
        #1;
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, expected 1", busy[0]); end
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk_out); lat++; #1;
            if (update_out[0]) got = 1'b1;
        end
        checks++;
        if (!got || lat < SS + 1 || lat > SS + 2) begin
            errors++;
            $display("FAIL single_latency: got %0d clk_out edges (seen=%0d), expected %0d..%0d", lat, got, SS + 1, SS + 2);
        end
        checks++;
        if (out_ch(1) !== 16'h0000) begin errors++; $display("FAIL single_ch1: got 0x%h, expected 0x0000", out_ch(1)); end
        drain("single");
        checks++;
        if (out_ch(0) !== 16'h1234) begin errors++; $display("FAIL single_value: got 0x%h, expected 0x1234", out_ch(0)); end
    endtask

    task automatic test_back_to_back();
        int u0 = upd_cnt[0];
        @(posedge clk_in); #1 set_ch(0, 16'h0001);
        @(posedge clk_in);
        expect_launch(0, 16'h0001);
        #1 set_ch(0, 16'h0002);
        @(posedge clk_in); #1 set_ch(0, 16'h0003);
        @(posedge clk_in); #1;
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b, expected 1", busy[0]); end
        expect_launch(0, 16'h0003);
        drain("b2b");
        checks++;
        if (upd_cnt[0] - u0 != 2) begin errors++; $display("FAIL b2b_count: got %0d pulses, expected 2", upd_cnt[0] - u0); end
        checks++;
        if (out_ch(0) !== 16'h0003) begin errors++; $display("FAIL b2b_value: got 0x%h, expected 0x0003", out_ch(0)); end
    endtask

    task automatic test_force();
        int u1;
        @(posedge clk_in); #1 set_ch(1, 16'hBEEF);
        @(posedge clk_in);
        expect_launch(1, 16'hBEEF);
        drain("force_setup");
        u1 = upd_cnt[1];
        @(posedge clk_in); #1 force_in[1] = 1'b1;
        @(posedge clk_in); #1 force_in[1] = 1'b0;
        expect_launch(1, 16'hBEEF);
        drain("force_single");
        checks++;
        if (upd_cnt[1] - u1 != 1) begin errors++; $display("FAIL force_single: got %0d pulses, expected 1", upd_cnt[1] - u1); end
        // One force to start a transfer, then three more while it is in flight.
        u1 = upd_cnt[1];
        @(posedge clk_in); #1 force_in[1] = 1'b1;
        @(posedge clk_in); #1 force_in[1] = 1'b0;
        @(posedge clk_in);
        expect_launch(1, 16'hBEEF);
        #1;
        checks++;
        if (busy[1] !== 1'b1) begin errors++; $display("FAIL force_busy: got %b, expected 1", busy[1]); end
        force_in[1] = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 force_in[1] = 1'b0;
        expect_launch(1, 16'hBEEF);
        drain("force_merge");
        checks++;
        if (upd_cnt[1] - u1 != 2) begin errors++; $display("FAIL force_merge: got %0d pulses, expected 2", upd_cnt[1] - u1); end
        checks++;
        if (out_ch(1) !== 16'hBEEF) begin errors++; $display("FAIL force_value: got 0x%h, expected 0xbeef", out_ch(1)); end
    endtask

    task automatic test_dst_reset();
        // The reload after a destination reset needs req=1, so make the 0x00AA launch an odd toggle.
        if (tog[0] % 2 == 1) begin
            @(posedge clk_in); #1 set_ch(0, 16'h0055);
            @(posedge clk_in);
            expect_launch(0, 16'h0055);
            drain("dst_filler");
        end
        sb_en = 1'b0;
        @(posedge clk_in); #1 set_ch(0, 16'h00AA);
        @(posedge clk_in);
        tog[0]++;
        @(posedge clk_out); #1 reset_n_clk_out = 1'b0;
        repeat (2) @(posedge clk_out);
        #1;
        checks++;
        if (out_ch(0) !== 16'h0000) begin errors++; $display("FAIL dst_reset_clear: got 0x%h, expected 0x0000", out_ch(0)); end
        reset_n_clk_out = 1'b1;
        drain("dst_reset");
        checks++;
        if (out_ch(0) !== 16'h00AA) begin errors++; $display("FAIL dst_reset_value: got 0x%h, expected 0x00aa", out_ch(0)); end
        checks++;
        if (busy !== '0) begin errors++; $display("FAIL dst_reset_busy: got %b, expected 0", busy); end
        sb_en = 1'b1;
    endtask

    task automatic test_src_reset();
        sb_en = 1'b0;
        @(posedge clk_in); #1 set_ch(0, 16'h1111);
        @(posedge clk_in); #1 reset_n_clk_in = 1'b0;
        #1;
        checks++;
        if (busy !== '0) begin errors++; $display("FAIL src_reset_busy: got %b, expected 0", busy); end
        @(posedge clk_in); #1 reset_n_clk_in = 1'b1;
        drain("src_reset");
        sb_en = 1'b1;
        @(posedge clk_in); #1 set_ch(0, 16'h5555);
        @(posedge clk_in);
        expect_launch(0, 16'h5555);
        drain("src_after");
        checks++;
        if (out_ch(0) !== 16'h5555) begin errors++; $display("FAIL src_reset_value: got 0x%h, expected 0x5555", out_ch(0)); end
        checks++;
        if (busy !== '0) begin errors++; $display("FAIL src_reset_idle: got %b, expected 0", busy); end
    endtask

    initial begin
        reset_n_clk_in  = 1'b0;
        reset_n_clk_out = 1'b0;
        bus_in   = '0;
        force_in = '0;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) test_reset(2, 4);   // clk_in 250 MHz, clk_out 125 MHz
            else           test_reset(4, 2);   // clk_out faster than clk_in
            test_single();
            test_back_to_back();
            test_force();
            test_dst_reset();
            test_src_reset();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
